row_classifier: RTL and testbench

- Sequencer and arg-max stage that wraps the row multiplier.
- Steps `row_select` through all output rows and issues one `begin_mult` pulse per row.
- Captures each `row_result` and tracks the running maximum.
- After the last row, reports the winning class index (digit 0-9) to the top-level controller.

---
 rtl/classifier_pkg.sv | 20 ++
 rtl/row_classifier_if.sv | 33 +++
 rtl/score_tracker.sv | 29 ++
 rtl/row_classifier.sv | 130 +++++++++++++
 tb/tb_row_classifier.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/classifier_pkg.sv
// Shared constants and FSM state type for the row classifier slice.
// SCORE_MIN is the most-negative signed score and seeds the arg-max search.
package classifier_pkg;

   localparam int NUM_ROWS    = 10;
   localparam int RESULT_W    = 16;
   localparam int SEL_W       = 4;
   localparam int TIMEOUT_DEF = 2048;

   localparam logic [RESULT_W-1:0] SCORE_MIN = {1'b1, {(RESULT_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/row_classifier_if.sv
// Controller- and multiplier-facing signals of the row classifier.
// Handshake: start, begin_mult and class_valid are single-cycle pulses sampled on the rising clock edge.
interface row_classifier_if;
   import classifier_pkg::*;

   logic                start;
   logic                done_row;
   logic                w_result_ena;
   logic [RESULT_W-1:0] row_result;
   logic                overflow;
   logic                begin_mult;
   logic [SEL_W-1:0]    row_select;
   logic                busy;
   logic                class_valid;
   logic [SEL_W-1:0]    class_out;
   logic [RESULT_W-1:0] max_score;
   logic [NUM_ROWS-1:0] ovf_mask;
   logic                timeout_err;
   state_t              dbg_state;

   modport master (
      output start, done_row, w_result_ena, row_result, overflow,
      input  begin_mult, row_select, busy, class_valid, class_out,
      input  max_score, ovf_mask, timeout_err, dbg_state
   );

   modport slave (
      input  start, done_row, w_result_ena, row_result, overflow,
      output begin_mult, row_select, busy, class_valid, class_out,
      output max_score, ovf_mask, timeout_err, dbg_state
   );

endinterface

// File: rtl/score_tracker.sv
// Running arg-max: keeps the best signed score and its row index.
// Strict greater-than means ties keep the earlier (lower) row.
module score_tracker
   import classifier_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                update,
   input  logic [RESULT_W-1:0] score,
   input  logic [SEL_W-1:0]    idx,
   output logic [RESULT_W-1:0] max_score,
   output logic [SEL_W-1:0]    class_out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_score <= SCORE_MIN;
         class_out <= '0;
      end else if (init) begin
         max_score <= SCORE_MIN;
         class_out <= '0;
      end else if (update && ($signed(score) > $signed(max_score))) begin
         max_score <= score;
         class_out <= idx;
      end
   end

endmodule

// File: rtl/row_classifier.sv
// Sequences the row multiplier over all rows, excludes bad rows and reports the arg-max class.
// A per-row watchdog aborts the image if the multiplier never signals done_row.
module row_classifier
   import classifier_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   row_classifier_if.slave bus
);

   localparam int WD_W = $clog2(TIMEOUT);

   state_t              state;
   state_t              state_nx;
   logic [SEL_W-1:0]    idx;
   logic                captured;
   logic                lat_ovf;
   logic [RESULT_W-1:0] lat_result;
   logic [WD_W-1:0]     wdog;
   logic [NUM_ROWS-1:0] ovf_mask;
   logic                timeout_err;
   logic                wd_expired;
   logic                last_row;
   logic                row_excluded;
   logic                init_scores;
   logic                update_score;

   assign wd_expired   = (wdog == WD_W'(TIMEOUT - 1));
   assign last_row     = (idx == SEL_W'(NUM_ROWS - 1));
   assign row_excluded = !captured || lat_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      init_scores  = 1'b0;
      update_score = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nx    = ST_ISSUE;
               init_scores = 1'b1;
            end
         end
         ST_ISSUE: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (bus.done_row)     state_nx = ST_NEXT;
            else if (wd_expired)  state_nx = ST_DONE;
         end
         ST_NEXT: begin
            update_score = !row_excluded;
            state_nx     = last_row ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Capture uses the cycle's own data even when done_row arrives with w_result_ena.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         captured    <= 1'b0;
         lat_ovf     <= 1'b0;
         lat_result  <= '0;
         wdog        <= '0;
         ovf_mask    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  idx         <= '0;
                  ovf_mask    <= '0;
                  timeout_err <= 1'b0;
               end
            end
            ST_ISSUE: begin
               captured <= 1'b0;
               wdog     <= '0;
            end
            ST_WAIT: begin
               if (bus.w_result_ena) begin
                  lat_result <= bus.row_result;
                  lat_ovf    <= bus.overflow;
                  captured   <= 1'b1;
               end
               if (!bus.done_row) begin
                  if (wd_expired) begin
                     timeout_err <= 1'b1;
                     ovf_mask    <= ovf_mask | (NUM_ROWS'(1) << idx);
                  end else begin
                     wdog <= wdog + WD_W'(1);
                  end
               end
            end
            ST_NEXT: begin
               if (row_excluded) ovf_mask <= ovf_mask | (NUM_ROWS'(1) << idx);
               if (!last_row)    idx <= idx + SEL_W'(1);
            end
            default: ;
         endcase
      end
   end

   score_tracker u_tracker (
      .clk       (clk),
      .rst       (rst),
      .init      (init_scores),
      .update    (update_score),
      .score     (lat_result),
      .idx       (idx),
      .max_score (bus.max_score),
      .class_out (bus.class_out)
   );

   assign bus.begin_mult  = (state == ST_ISSUE);
   assign bus.row_select  = idx;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.class_valid = (state == ST_DONE);
   assign bus.ovf_mask    = ovf_mask;
   assign bus.timeout_err = timeout_err;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_row_classifier.sv
// Bench for row_classifier: behavioural multiplier, queue scoreboard and an arg-max reference model.
module tb_row_classifier;
   import classifier_pkg::*;

   localparam int TIMEOUT = 2048;
   localparam int RW      = SEL_W + RESULT_W + NUM_ROWS + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   row_classifier_if bus ();

   row_classifier #(.TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [RW-1:0]    exp_q[$];
   logic [SEL_W-1:0] sel_q[$];

   int score_tab[NUM_ROWS];
   bit ovf_tab[NUM_ROWS];
   bit noena_tab[NUM_ROWS];
   bit hang_tab[NUM_ROWS];
   int nominal[NUM_ROWS] = '{5, 12, -3, 40, 7, 40, 0, 1, 2, -9};
   int lat = 20;

   int cycle = 0;
   int last_begin_cycle = 0;
   int cnt = 0;
   int cur = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference model: walk the rows in order, keep the first strictly-best clean score.
   task automatic push_expect();
      int best = -32768;
      int best_idx = 0;
      logic [NUM_ROWS-1:0] mask = '0;
      bit to = 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         sel_q.push_back(SEL_W'(r));
         if (hang_tab[r]) begin
            mask[r] = 1'b1;
            to = 1'b1;
            break;
         end
         if (noena_tab[r] || ovf_tab[r]) mask[r] = 1'b1;
         else if (score_tab[r] > best) begin
            best = score_tab[r];
            best_idx = r;
         end
      end
      exp_q.push_back({SEL_W'(best_idx), RESULT_W'(best), mask, to});
   endtask

   task automatic set_nominal();
      for (int r = 0; r < NUM_ROWS; r++) begin
         score_tab[r] = nominal[r];
         ovf_tab[r]   = 1'b0;
         noena_tab[r] = 1'b0;
         hang_tab[r]  = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_image();
      push_expect();
      pulse_start();
      check("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s: no class_valid within %0d cycles, required one", name, budget);
         exp_q.delete();
         sel_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_row(input int r, input int budget, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (bus.begin_mult && bus.row_select == SEL_W'(r)) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s: begin_mult for row %0d not seen within %0d cycles", name, r, budget);
      end
   endtask

   // Behavioural multiplier: done_row (with result unless suppressed) lat cycles after begin_mult.
   always @(negedge clk) begin
      bus.done_row     = 1'b0;
      bus.w_result_ena = 1'b0;
      bus.overflow     = 1'b0;
      bus.row_result   = '0;
      if (rst) cnt = 0;
      else if (bus.begin_mult) begin
         cur = int'(bus.row_select);
         cnt = lat;
      end else if (cnt > 0) begin
         cnt--;
         if (cnt == 0 && cur < NUM_ROWS && !hang_tab[cur]) begin
            bus.done_row     = 1'b1;
            bus.w_result_ena = !noena_tab[cur];
            bus.row_result   = RESULT_W'(score_tab[cur]);
            bus.overflow     = ovf_tab[cur];
         end
      end
   end

   // Monitor: checks every begin_mult and every class_valid against the queues.
   always @(negedge clk) begin
      logic [RW-1:0] e;
      int el;
      cycle++;
      if (!rst && bus.begin_mult) begin
         last_begin_cycle = cycle;
         if (sel_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL begin_mult: unexpected pulse for row_select=%0d, none required", bus.row_select);
         end else begin
            check("row_select", 32'(bus.row_select), 32'(sel_q.pop_front()));
         end
      end
      if (!rst && bus.class_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL class_valid: unexpected pulse, class_out=%0d, none required", bus.class_out);
         end else begin
            e = exp_q.pop_front();
            check("rows_issued_left", 32'(sel_q.size()), 32'd0);
            check("class_out",   32'(bus.class_out),   32'(e[RW-1 -: SEL_W]));
            check("max_score",   32'(bus.max_score),   32'(e[NUM_ROWS+RESULT_W -: RESULT_W]));
            check("ovf_mask",    32'(bus.ovf_mask),    32'(e[NUM_ROWS:1]));
            check("timeout_err", 32'(bus.timeout_err), 32'(e[0]));
            if (e[0]) begin
               el = cycle - last_begin_cycle;
               vectors++;
               if (el < TIMEOUT || el > TIMEOUT + 2) begin
                  miscompares++;
                  $display("FAIL timeout_delay: got %0d cycles, required %0d..%0d", el, TIMEOUT, TIMEOUT + 2);
               end
            end
            sel_q.delete();
         end
      end
   end

   initial begin
      bus.start        = 1'b0;
      bus.done_row     = 1'b0;
      bus.w_result_ena = 1'b0;
      bus.row_result   = '0;
      bus.overflow     = 1'b0;
      set_nominal();

      repeat (3) @(negedge clk);
      check("rst_begin_mult",  32'(bus.begin_mult),  32'd0);
      check("rst_busy",        32'(bus.busy),        32'd0);
      check("rst_class_valid", 32'(bus.class_valid), 32'd0);
      check("rst_row_select",  32'(bus.row_select),  32'd0);
      check("rst_class_out",   32'(bus.class_out),   32'd0);
      check("rst_max_score",   32'(bus.max_score),   32'h8000);
      check("rst_ovf_mask",    32'(bus.ovf_mask),    32'd0);
      check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal: class 3 wins the 40/40 tie against row 5
      set_nominal();
      lat = 20;
      run_image();
      wait_idle("nominal", 600);

      set_nominal();
      score_tab[3] = 32767;
      ovf_tab[3] = 1'b1;
      run_image();
      wait_idle("overflow_excl", 600);

      set_nominal();
      lat = $urandom_range(1, 25);
      for (int r = 0; r < NUM_ROWS; r++) score_tab[r] = -100;
      score_tab[9] = -1;
      run_image();
      wait_idle("all_negative", 600);

      set_nominal();
      for (int r = 0; r < NUM_ROWS; r++) ovf_tab[r] = 1'b1;
      run_image();
      wait_idle("all_excluded", 600);

      set_nominal();
      noena_tab[2] = 1'b1;
      run_image();
      wait_idle("missing_capture", 600);

      set_nominal();
      hang_tab[4] = 1'b1;
      run_image();
      wait_idle("timeout", TIMEOUT + 600);
      check("timeout_err_held", 32'(bus.timeout_err), 32'd1);

      // Async reset in the middle of row 6, between clock edges
      set_nominal();
      lat = 20;
      run_image();
      wait_row(6, 600, "reach_row6");
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      exp_q.delete();
      sel_q.delete();
      #1;
      check("midrst_begin_mult",  32'(bus.begin_mult),  32'd0);
      check("midrst_busy",        32'(bus.busy),        32'd0);
      check("midrst_row_select",  32'(bus.row_select),  32'd0);
      check("midrst_class_valid", 32'(bus.class_valid), 32'd0);
      check("midrst_max_score",   32'(bus.max_score),   32'h8000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      score_tab[7] = 77;
      run_image();
      wait_idle("after_reset", 600);

      // Start while busy must be ignored
      set_nominal();
      lat = 12;
      run_image();
      wait_row(4, 400, "reach_row4");
      pulse_start();
      wait_idle("start_while_busy", 600);
      score_tab[0] = 90;
      run_image();
      wait_idle("start_after_done", 600);

      for (int t = 0; t < 8; t++) begin
         set_nominal();
         lat = $urandom_range(1, 25);
         for (int r = 0; r < NUM_ROWS; r++) begin
            if (t[0]) score_tab[r] = int'($urandom_range(0, 65535)) - 32768;
            else      score_tab[r] = int'($urandom_range(0, 40)) - 20;
            ovf_tab[r]   = ($urandom_range(0, 7) == 0);
            noena_tab[r] = ($urandom_range(0, 9) == 0);
         end
         run_image();
         wait_idle("random", 600);
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
